// File: rtl/ant_rt_scheduler_if.sv
// Lane request / table command bundle shared by the ant routing-table scheduler.
// The scheduler sits on the slave modport; lanes and the table sit on the master side.
`ifndef N
`define N 5
`endif
`ifndef NODES
`define NODES 64
`endif

interface ant_rt_scheduler_if #(
  parameter int N      = `N,
  parameter int DEST_W = $clog2(`NODES)
);
  logic [0:N-1]             i_req;
  logic [0:N-1]             i_req_update;
  logic [0:N-1][DEST_W-1:0] i_req_dest;
  logic [0:N-1]             o_ack;
  logic [N-1:0]             o_next_output;
  logic                     o_rt_calculate;
  logic                     o_rt_update;
  logic [DEST_W-1:0]        o_rt_dest;
  logic [0:N-1]             o_rt_parent;
  logic [N-1:0]             i_rt_next_output;
  logic                     o_busy;
  logic                     o_err;

  modport master (
    output i_req, i_req_update, i_req_dest, i_rt_next_output,
    input  o_ack, o_next_output, o_rt_calculate, o_rt_update,
           o_rt_dest, o_rt_parent, o_busy, o_err
  );

  modport slave (
    input  i_req, i_req_update, i_req_dest, i_rt_next_output,
    output o_ack, o_next_output, o_rt_calculate, o_rt_update,
           o_rt_dest, o_rt_parent, o_busy, o_err
  );
endinterface

// File: rtl/ant_rt_scheduler.sv
// Round-robin arbiter serialising lane requests onto the single-ported ant routing table.
// Each grant runs IDLE -> ISSUE (strobe) -> WAIT (capture result), ack on the edge ending WAIT.
`ifndef N
`define N 5
`endif
`ifndef NODES
`define NODES 64
`endif

module ant_rt_scheduler #(
  parameter int N      = `N,
  parameter int DEST_W = $clog2(`NODES)
) (
  input  logic          clk,
  input  logic          reset,
  ant_rt_scheduler_if.slave bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic             op;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic [IDX_W:0]   cand;

  function automatic logic [0:N-1] lane_onehot(input logic [IDX_W-1:0] idx);
    logic [0:N-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  // First requesting lane at or after rr_ptr, wrapping N-1 -> 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && bus.i_req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      win                <= '0;
      op                 <= 1'b0;
      bus.o_ack          <= '0;
      bus.o_next_output  <= '0;
      bus.o_rt_calculate <= 1'b0;
      bus.o_rt_update    <= 1'b0;
      bus.o_rt_dest      <= '0;
      bus.o_rt_parent    <= '0;
      bus.o_busy         <= 1'b0;
      bus.o_err          <= 1'b0;
    end else begin
      bus.o_ack          <= '0;
      bus.o_rt_calculate <= 1'b0;
      bus.o_rt_update    <= 1'b0;
      bus.o_rt_dest      <= '0;
      bus.o_rt_parent    <= '0;
      case (state)
        IDLE: begin
          // The command registers double as the latch of the winner's request.
          if (found) begin
            state              <= ISSUE;
            win                <= pick;
            op                 <= bus.i_req_update[pick];
            bus.o_rt_calculate <= ~bus.i_req_update[pick];
            bus.o_rt_update    <= bus.i_req_update[pick];
            bus.o_rt_dest      <= bus.i_req_dest[pick];
            bus.o_rt_parent    <= lane_onehot(pick);
            bus.o_busy         <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
          bus.o_ack  <= lane_onehot(win);
          rr_ptr     <= (win == IDX_W'(N-1)) ? '0 : win + IDX_W'(1);
          if (!op) begin
            bus.o_next_output <= bus.i_rt_next_output;
            if (!is_onehot(bus.i_rt_next_output)) bus.o_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ant_rt_scheduler.sv
// Scoreboard bench for ant_rt_scheduler: directed lane requests, a registered table model,
// and a monitor that checks every table command and every acknowledge against queued expectations.
module tb_ant_rt_scheduler;
  localparam int N      = 5;
  localparam int DEST_W = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ant_rt_scheduler_if #(.N(N), .DEST_W(DEST_W)) bus();
  ant_rt_scheduler #(.N(N), .DEST_W(DEST_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int lane; logic [N-1:0] nxt; logic err;} ack_exp_t;
  typedef struct {logic upd; logic [DEST_W-1:0] dest; int lane;} cmd_exp_t;
  ack_exp_t ack_q[$];
  cmd_exp_t cmd_q[$];
  ack_exp_t ae;
  cmd_exp_t ce;

  logic [N-1:0] resp_tab [N];

  function automatic logic [0:N-1] lane_vec(input int l);
    logic [0:N-1] v;
    v    = '0;
    v[l] = 1'b1;
    return v;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Table model: registered output, valid the cycle after a strobe; junk on update.
  always @(posedge clk) begin
    if (bus.o_rt_calculate) begin
      for (int k = 0; k < N; k++)
        if (bus.o_rt_parent[k]) bus.i_rt_next_output <= resp_tab[k];
    end else if (bus.o_rt_update) begin
      bus.i_rt_next_output <= '1;
    end else begin
      bus.i_rt_next_output <= '0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_rt_calculate || bus.o_rt_update) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", 32'(bus.o_rt_parent), 32'(0));
        end else begin
          ce = cmd_q.pop_front();
          check("cmd_calc",   32'(bus.o_rt_calculate), 32'(!ce.upd));
          check("cmd_update", 32'(bus.o_rt_update),    32'(ce.upd));
          check("cmd_dest",   32'(bus.o_rt_dest),      32'(ce.dest));
          check("cmd_parent", 32'(bus.o_rt_parent),    32'(lane_vec(ce.lane)));
          check("cmd_busy",   32'(bus.o_busy),         32'(1));
        end
      end
      if (bus.o_ack != '0) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 32'(bus.o_ack), 32'(0));
        end else begin
          ae = ack_q.pop_front();
          check("ack_vec",  32'(bus.o_ack),         32'(lane_vec(ae.lane)));
          check("ack_next", 32'(bus.o_next_output), 32'(ae.nxt));
          check("ack_err",  32'(bus.o_err),         32'(ae.err));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int lane, output int lat);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      lat++;
      if (bus.o_ack[lane]) return;
    end
    check("ack_timeout", 32'(lane), 32'(lane + 100));
  endtask

  task automatic send(input int lane, input logic upd, input logic [DEST_W-1:0] dest,
                      input logic [N-1:0] resp, input logic [N-1:0] exp_nxt, input logic exp_err);
    int lat;
    resp_tab[lane] = resp;
    cmd_q.push_back('{upd: upd, dest: dest, lane: lane});
    ack_q.push_back('{lane: lane, nxt: exp_nxt, err: exp_err});
    bus.i_req_update[lane] = upd;
    bus.i_req_dest[lane]   = dest;
    bus.i_req[lane]        = 1'b1;
    wait_ack(lane, lat);
    bus.i_req[lane] = 1'b0;
    check("latency", 32'(lat), 32'(3));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},    32'(bus.o_ack),          32'(0));
    check({tag, "_next"},   32'(bus.o_next_output),  32'(0));
    check({tag, "_calc"},   32'(bus.o_rt_calculate), 32'(0));
    check({tag, "_upd"},    32'(bus.o_rt_update),    32'(0));
    check({tag, "_dest"},   32'(bus.o_rt_dest),      32'(0));
    check({tag, "_parent"}, 32'(bus.o_rt_parent),    32'(0));
    check({tag, "_busy"},   32'(bus.o_busy),         32'(0));
    check({tag, "_err"},    32'(bus.o_err),          32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int prev_cyc;
    int exp_lane;
    bus.i_req        = '0;
    bus.i_req_update = '0;
    bus.i_req_dest   = '0;
    for (int k = 0; k < N; k++) resp_tab[k] = '0;
    reset = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Single calculate, lane 2
    send(2, 1'b0, 6'd19, 5'b00100, 5'b00100, 1'b0);

    // Lane 3 calculate with dest changed during ISSUE
    resp_tab[3] = 5'b01000;
    cmd_q.push_back('{upd: 1'b0, dest: 6'd10, lane: 3});
    ack_q.push_back('{lane: 3, nxt: 5'b01000, err: 1'b0});
    bus.i_req_update[3] = 1'b0;
    bus.i_req_dest[3]   = 6'd10;
    bus.i_req[3]        = 1'b1;
    tick();
    check("issue_busy", 32'(bus.o_busy), 32'(1));
    bus.i_req_dest[3] = 6'd40;
    wait_ack(3, lat);
    bus.i_req[3] = 1'b0;
    check("late_dest_latency", 32'(lat), 32'(2));

    // Update on lane 4 keeps the previous table result
    send(4, 1'b1, 6'd63, 5'b00001, 5'b01000, 1'b0);

    // Round robin: all lanes continuously requesting from rr_ptr = 0
    for (int k = 0; k < N; k++) begin
      resp_tab[k]         = 5'(1 << k);
      bus.i_req_update[k] = 1'b0;
      bus.i_req_dest[k]   = 6'(k * 7 + 1);
    end
    for (int j = 0; j < 6; j++) begin
      exp_lane = j % N;
      cmd_q.push_back('{upd: 1'b0, dest: 6'(exp_lane * 7 + 1), lane: exp_lane});
      ack_q.push_back('{lane: exp_lane, nxt: 5'(1 << exp_lane), err: 1'b0});
    end
    bus.i_req = '1;
    prev_cyc  = 0;
    for (int j = 0; j < 6; j++) begin
      wait_ack(j % N, lat);
      if (j > 0) check("rr_spacing", 32'(cyc - prev_cyc), 32'(3));
      prev_cyc = cyc;
    end
    bus.i_req = '0;

    // Error flag: zero vector, then multi-hot vector; sticky until reset
    send(0, 1'b0, 6'd3, 5'b00000, 5'b00000, 1'b1);
    send(1, 1'b0, 6'd4, 5'b00011, 5'b00011, 1'b1);
    repeat (4) tick();
    check("err_sticky", 32'(bus.o_err), 32'(1));
    reset = 1'b1;
    tick();
    check("err_cleared", 32'(bus.o_err), 32'(0));
    reset = 1'b0;

    // Reset during WAIT: request discarded, re-served after reset
    resp_tab[1] = 5'b00010;
    cmd_q.push_back('{upd: 1'b0, dest: 6'd5, lane: 1});
    bus.i_req_update[1] = 1'b0;
    bus.i_req_dest[1]   = 6'd5;
    bus.i_req[1]        = 1'b1;
    tick();
    tick();
    check("wait_busy", 32'(bus.o_busy), 32'(1));
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    cmd_q.push_back('{upd: 1'b0, dest: 6'd5, lane: 1});
    ack_q.push_back('{lane: 1, nxt: 5'b00010, err: 1'b0});
    wait_ack(1, lat);
    bus.i_req[1] = 1'b0;
    check("post_reset_latency", 32'(lat), 32'(3));

    repeat (5) tick();
    check("idle_after", 32'(bus.o_busy), 32'(0));
    check("ack_q_drained", 32'(ack_q.size()), 32'(0));
    check("cmd_q_drained", 32'(cmd_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
